// File: rtl/wb_pkg.sv
// Shared types for the data-cache posted write buffer: queue entry, drain FSM
// states, single-beat AXI constants and the byte-merge helper.
package wb_pkg;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } wb_state_t;

    localparam logic [7:0] AWLEN_SINGLE = 8'd0;
    localparam logic [2:0] AWSIZE_WORD  = 3'b010;
    localparam logic [1:0] AWBURST_INCR = 2'b01;

    // Replace the bytes of old_data selected by strb with those of new_data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Entry storage for the write buffer: pointers, full/empty, address lookup and
// (with D_WRITE_BUFFER_MERGE_EN) merging of a push into the newest entry.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  wb_entry_t   push_entry,
    input  logic        pop,
    input  logic        head_lock,
    input  logic [29:0] lookup_addr,
    output logic        full,
    output logic        empty,
    output logic        merge_ok,
    output wb_entry_t   head_entry,
    output logic        lookup_hit
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      head;
    logic [AW:0]      tail;
    logic [AW-1:0]    head_idx;
    logic [AW-1:0]    tail_idx;
    logic [AW-1:0]    last_idx;
    logic [DEPTH-1:0] valid;
    wb_entry_t        mem [DEPTH];

    assign head_idx   = head[AW-1:0];
    assign tail_idx   = tail[AW-1:0];
    assign last_idx   = tail_idx - 1'b1;
    assign empty      = (head == tail);
    assign full       = (head[AW] != tail[AW]) && (head_idx == tail_idx);
    assign head_entry = mem[head_idx];

`ifdef D_WRITE_BUFFER_MERGE_EN
    // The head is off limits once the drain FSM has latched or is about to latch it.
    assign merge_ok = !empty && valid[last_idx] && (mem[last_idx].addr == push_entry.addr)
                      && !((last_idx == head_idx) && head_lock);
`else
    logic unused_lock;
    assign unused_lock = head_lock;
    assign merge_ok    = 1'b0;
`endif

    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (mem[i].addr == lookup_addr)) begin
                lookup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head_idx] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push && !merge_ok) begin
                valid[tail_idx] <= 1'b1;
                tail            <= tail + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !merge_ok) begin
            mem[tail_idx] <= push_entry;
        end else if (push && merge_ok) begin
            mem[last_idx].data <= merge_bytes(mem[last_idx].data, push_entry.data, push_entry.strb);
            mem[last_idx].strb <= mem[last_idx].strb | push_entry.strb;
        end
    end

endmodule

// File: rtl/d_write_buffer.sv
// Posted write buffer draining queued cache writes as single-beat AXI writes.
// Optional D_WRITE_BUFFER_MERGE_EN merges same-word pushes into the newest entry.
module d_write_buffer
    import wb_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] AXI_ID = 4'h1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_strb,
    input  logic [31:0] lookup_addr,
    output logic        lookup_hit,
    output logic        empty,
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready
);

    wb_state_t   state, state_n;
    logic        aw_done, aw_done_n;
    logic        w_done, w_done_n;
    logic        awvalid_n, wvalid_n;
    logic [31:0] awaddr_n, wdata_n;
    logic [3:0]  wstrb_n;

    logic        fifo_full, fifo_empty, merge_ok, head_lock, push, pop;
    wb_entry_t   push_entry, head_entry;

    logic unused_ok;
    assign unused_ok = ^{bresp, req_addr[1:0], lookup_addr[1:0]};

    assign awid    = AXI_ID;
    assign awlen   = AWLEN_SINGLE;
    assign awsize  = AWSIZE_WORD;
    assign awburst = AWBURST_INCR;
    assign wid     = AXI_ID;
    assign wlast   = 1'b1;

    assign push_entry = '{addr: req_addr[31:2], data: req_data, strb: req_strb};
    assign req_ready  = !fifo_full || merge_ok;
    assign push       = req_valid && req_ready;
    assign pop        = (state == ST_RESP) && bvalid;
    assign head_lock  = (state != ST_IDLE) || !fifo_empty;
    assign bready     = (state == ST_RESP);
    assign empty      = fifo_empty && (state == ST_IDLE);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (aclk),
        .rst_n       (aresetn),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head_lock   (head_lock),
        .lookup_addr (lookup_addr[31:2]),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .merge_ok    (merge_ok),
        .head_entry  (head_entry),
        .lookup_hit  (lookup_hit)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            awvalid <= awvalid_n;
            wvalid  <= wvalid_n;
            awaddr  <= awaddr_n;
            wdata   <= wdata_n;
            wstrb   <= wstrb_n;
        end
    end

    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        awvalid_n = awvalid;
        wvalid_n  = wvalid;
        awaddr_n  = awaddr;
        wdata_n   = wdata;
        wstrb_n   = wstrb;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    awaddr_n  = {head_entry.addr, 2'b00};
                    wdata_n   = head_entry.data;
                    wstrb_n   = head_entry.strb;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    state_n   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Each valid rises on the first ISSUE cycle and falls after its own handshake.
                awvalid_n = awvalid ? !awready : !aw_done;
                wvalid_n  = wvalid ? !wready : !w_done;
                aw_done_n = aw_done || (awvalid && awready);
                w_done_n  = w_done || (wvalid && wready);
                if (aw_done_n && w_done_n) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bvalid) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_d_write_buffer.sv
// Scoreboard bench for d_write_buffer: directed scenarios plus randomized traffic,
// with a queue model of the posted writes checked by a negedge monitor.
module tb_d_write_buffer;

    localparam int         DEPTH  = 4;
    localparam logic [3:0] AXI_ID = 4'h1;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_strb;
    logic [31:0] lookup_addr;
    logic        lookup_hit, empty;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    int checks   = 0;
    int failures = 0;

    // Model: words queued but not yet responded, plus AW/W beats still owed.
    logic [29:0] exp_q[$];
    logic [31:0] exp_aw_q[$];
    logic [35:0] exp_w_q[$];

    d_write_buffer #(.DEPTH(DEPTH), .AXI_ID(AXI_ID)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_strb(req_strb),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .empty(empty),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_hit(input logic [31:0] a);
        logic h = 1'b0;
        foreach (exp_q[i]) if (exp_q[i] == a[31:2]) h = 1'b1;
        return h;
    endfunction

    // Monitor: check every cycle, then advance the model with the handshakes of the coming edge.
    always @(negedge aclk) begin
        int pre_size;
        if (!aresetn) begin
            exp_q.delete();
            exp_aw_q.delete();
            exp_w_q.delete();
        end else begin
            pre_size = exp_q.size();
            chk("req_ready", req_ready, pre_size < DEPTH);
            chk("empty", empty, pre_size == 0);
            chk("lookup_hit", lookup_hit, model_hit(lookup_addr));
            if (awvalid)
                chk("aw_legal", exp_aw_q.size() == pre_size && pre_size != 0, 1);
            if (wvalid)
                chk("w_legal", exp_w_q.size() == pre_size && pre_size != 0, 1);
            if (awvalid && awready) begin
                if (exp_aw_q.size() == 0) chk("aw_extra", 1, 0);
                else chk("awaddr", awaddr, exp_aw_q.pop_front());
                chk("aw_const", {awid, awlen, awsize, awburst}, {AXI_ID, 8'h00, 3'b010, 2'b01});
            end
            if (wvalid && wready) begin
                if (exp_w_q.size() == 0) chk("w_extra", 1, 0);
                else chk("wdata_wstrb", {wdata, wstrb}, exp_w_q.pop_front());
                chk("w_const", {wid, wlast}, {AXI_ID, 1'b1});
            end
            if (bready) begin
                chk("resp_after_aw_w", exp_aw_q.size() + 1 == pre_size && exp_w_q.size() + 1 == pre_size, 1);
                if (bvalid && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (req_valid && pre_size < DEPTH) begin
                exp_q.push_back(req_addr[31:2]);
                exp_aw_q.push_back({req_addr[31:2], 2'b00});
                exp_w_q.push_back({req_data, req_strb});
            end
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_for(input int which, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge aclk);
            case (which)
                0: seen = empty;
                1: seen = bready;
                default: seen = wvalid;
            endcase
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_strb  = s;
    endtask

    initial begin
        aresetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
        lookup_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;

        // Reset values
        repeat (3) cyc();
        @(negedge aclk);
        chk("rst_ready_empty_hit", {req_ready, empty, lookup_hit}, 3'b110);
        chk("rst_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("rst_data", {awaddr, wdata, wstrb}, '0);
        cyc();
        aresetn = 1'b1;

        // Single write latency
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        drive_req(32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF);
        cyc();
        req_valid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        chk("lat_n1_awvalid", {awvalid, wvalid}, 2'b00);
        @(negedge aclk);
        chk("lat_n2_valids", {awvalid, wvalid}, 2'b11);
        chk("lat_n2_payload", {awaddr, wdata, wstrb}, {32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF});
        wait_for(0, "single_drain");

        // Fill with AW stalled; fifth request must be refused
        cyc();
        awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1));
            cyc();
        end
        drive_req(32'h0000_2000, 32'h5555_5555, 4'hF);
        repeat (3) cyc();
        @(negedge aclk);
        chk("full_ready", req_ready, 1'b0);
        cyc();
        req_valid = 1'b0;
        awready = 1'b1;
        wait_for(0, "full_drain");

        // Skewed handshake: W completes well before AW
        cyc();
        awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
        drive_req(32'h0000_3004, 32'h1234_5678, 4'h5);
        cyc();
        req_valid = 1'b0;
        wait_for(2, "skew_wvalid");
        @(negedge aclk);
        chk("skew_w_dropped", {wvalid, awvalid, bready}, 3'b010);
        @(negedge aclk);
        chk("skew_no_resp", {wvalid, awvalid, bready}, 3'b010);
        cyc();
        cyc();
        awready = 1'b1;
        wait_for(0, "skew_drain");

        // Lookup hit/miss and clear on pop
        cyc();
        awready = 1'b0;
        drive_req(32'h8000_0104, 32'h0BAD_F00D, 4'hC);
        cyc();
        req_valid = 1'b0;
        lookup_addr = 32'h8000_0107;
        @(negedge aclk);
        chk("lookup_same_word", lookup_hit, 1'b1);
        cyc();
        lookup_addr = 32'h8000_0108;
        @(negedge aclk);
        chk("lookup_next_word", lookup_hit, 1'b0);
        cyc();
        lookup_addr = 32'h8000_0104;
        awready = 1'b1;
        wait_for(1, "lookup_resp");
        chk("lookup_before_pop", lookup_hit, 1'b1);
        @(negedge aclk);
        chk("lookup_after_pop", lookup_hit, 1'b0);
        wait_for(0, "lookup_drain");

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            cyc();
            req_valid   = ($urandom_range(0, 2) != 0);
            req_addr    = 32'h4000_0000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            req_data    = $urandom;
            req_strb    = 4'($urandom_range(0, 15));
            lookup_addr = 32'h4000_0000 | ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
            awready     = ($urandom_range(0, 3) != 0);
            wready      = ($urandom_range(0, 3) != 0);
            bvalid      = ($urandom_range(0, 2) != 0);
        end
        cyc();
        req_valid = 1'b0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        wait_for(0, "random_drain");

        // Reset while waiting for the write response
        cyc();
        bvalid = 1'b0;
        drive_req(32'h0000_5000, 32'hCAFE_0001, 4'hF);
        cyc();
        drive_req(32'h0000_5004, 32'hCAFE_0002, 4'hF);
        cyc();
        req_valid = 1'b0;
        wait_for(1, "rst_resp_reach");
        cyc();
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_resp_valids", {awvalid, bready, wvalid}, 3'b000);
        chk("rst_resp_status", {empty, req_ready, lookup_hit}, 3'b110);
        repeat (3) @(negedge aclk);
        chk("rst_resp_quiet", {awvalid, wvalid, empty}, 3'b001);

        chk("model_clear", exp_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
